fifo_ctrl: RTL and testbench
============================

// Module: fifo_ctrl
// PURPOSE
//  Pointer/flag controller for the 8x32 fifo datapath; drives the register file's
//  wr_en/wr_addr/rd_addr and reports occupancy. Sits directly upstream of the
//  register file. Producer and consumer share one clock domain. Data does not pass
//  through this block; read data is taken from the register file's rdata.
// PARAMETERS
//  ADDR_W    3  address width; DEPTH = 2**ADDR_W entries (localparam)
//  AF_LEVEL  6  almost_full asserted when count >= AF_LEVEL
//  AE_LEVEL  2  almost_empty asserted when count <= AE_LEVEL
// PORTS
//  clk           in   1         rising-edge clock
//  rst           in   1         asynchronous, active-high reset
//  wr_req        in   1         producer requests a push this cycle
//  rd_req        in   1         consumer requests a pop this cycle
//  wr_en         out  1         register-file write strobe (accepted push)
//  wr_addr       out  ADDR_W    register-file write address
//  rd_addr       out  ADDR_W    register-file read address
//  rd_valid      out  1         register-file rdata holds popped word this cycle
//  full          out  1         DEPTH entries held
//  empty         out  1         zero entries held
//  almost_full   out  1         count >= AF_LEVEL
//  almost_empty  out  1         count <= AE_LEVEL
//  count         out  ADDR_W+1  entries held, 0..DEPTH
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk deassert by user): wr_ptr=rd_ptr=0, count=0,
//    empty=1, full=0, almost_empty=1, almost_full=0, rd_valid=0, wr_en=0.
//  - Pointers are ADDR_W+1 bits; low ADDR_W bits address memory; MSB is wrap bit.
//    full = (ptr MSBs differ, low bits equal); empty = (wr_ptr == rd_ptr).
//  - push_ok = wr_req & ~full; pop_ok = rd_req & ~empty; both from registered state.
//  - wr_en = push_ok (combinational); wr_addr = wr_ptr[ADDR_W-1:0].
//  - rd_addr = rd_ptr[ADDR_W-1:0] (combinational); register file samples it on the
//    same edge that advances rd_ptr, so popped word appears on rdata one cycle later.
//  - rd_valid <= pop_ok (1-cycle read latency, matches registered rdata).
//  - On clk: wr_ptr += push_ok; rd_ptr += pop_ok; count += push_ok - pop_ok.
//    Pointers wrap modulo 2*DEPTH with no special case.
//  - Simultaneous push+pop when neither full nor empty: both accepted, count unchanged.
//  - Push while full: rejected (wr_en=0) even if pop_ok same cycle; no state change.
//  - Pop while empty: rejected even if push same cycle; rd_valid=0 next cycle.
//  - Flags and count reflect state after the last edge; no lookahead.
//  - Reset mid-operation: all state returns to reset values immediately; any
//    in-flight rd_valid is cleared; memory contents are not cleared.
// CONFIGURATION
//  FIFO_ERR_FLAGS_EN defined: adds outputs overflow, underflow (1 bit each, reset 0).
//   overflow sets on clk when wr_req & full; underflow sets when rd_req & empty;
//   both sticky until rst. Flow behaviour otherwise unchanged.
//  Not defined: ports absent; rejected requests are silently dropped.
// TESTING (ADDR_W=3, AF_LEVEL=6, AE_LEVEL=2)
//  1. Reset, idle -> empty=1, full=0, count=0, almost_empty=1, rd_valid=0.
//  2. 8 pushes back-to-back -> wr_addr 0..7, count 1..8, almost_full at count 6,
//     full=1 after 8th edge; 9th wr_req -> wr_en=0, count stays 8 (overflow=1 if EN).
//  3. From full, 8 pops -> rd_addr 0..7, rd_valid one cycle after each pop, rdata
//     order matches push order, empty=1 after 8th edge; extra rd_req -> rd_valid=0.
//  4. count=4, push+pop together for 20 cycles -> count stays 4, pointers wrap past
//     addr 7 to 0 correctly, data order preserved.
//  5. Full + simultaneous wr_req & rd_req -> pop accepted, push rejected, count=7;
//     empty + both -> push accepted, pop rejected, count=1, rd_valid=0.
//  6. Assert rst mid-stream (count=5, pop in flight) -> same cycle count=0, empty=1,
//     rd_valid=0; after release, first push writes addr 0.

Source files
------------

// File: rtl/fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ctrl_if
// Description : Handshake/status bundle between a fifo_ctrl pointer/flag
//               controller and its producer/consumer + register-file side.
//               The error flags (overflow/underflow) exist only when the
//               macro FIFO_ERR_FLAGS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_ctrl_if #(
    parameter int ADDR_W = 3
);
    logic              wr_req;
    logic              rd_req;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
    logic              overflow;
    logic              underflow;

    // Producer/consumer side: issues requests, observes status.
    modport master (
        output wr_req, rd_req,
        input  wr_en, wr_addr, rd_addr, rd_valid, full, empty,
               almost_full, almost_empty, count, overflow, underflow
    );

    // Controller side: consumes requests, drives strobes/addresses/status.
    modport slave (
        input  wr_req, rd_req,
        output wr_en, wr_addr, rd_addr, rd_valid, full, empty,
               almost_full, almost_empty, count, overflow, underflow
    );
`else
    // Producer/consumer side: issues requests, observes status.
    modport master (
        output wr_req, rd_req,
        input  wr_en, wr_addr, rd_addr, rd_valid, full, empty,
               almost_full, almost_empty, count
    );

    // Controller side: consumes requests, drives strobes/addresses/status.
    modport slave (
        input  wr_req, rd_req,
        output wr_en, wr_addr, rd_addr, rd_valid, full, empty,
               almost_full, almost_empty, count
    );
`endif
endinterface
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ctrl
// Description : Pointer/flag controller for a 2**ADDR_W-entry register-file
//               FIFO. Generates write strobe, write/read addresses, a 1-cycle
//               read-valid, occupancy count and full/empty/almost flags.
//               Optional sticky overflow/underflow flags are built when the
//               macro FIFO_ERR_FLAGS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ctrl #(
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  wire          clk,
    input  wire          rst,
    fifo_ctrl_if.slave   bus
);

    localparam logic [ADDR_W:0] c_one      = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] c_af_level = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] c_ae_level = (ADDR_W+1)'(AE_LEVEL);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] count_q,  count_d;
    logic            rd_valid_q, rd_valid_d;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pop_ok;

    // Status decode and request qualification, all from registered state.
    always_comb begin
        w_full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                    (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
        w_empty   = (wr_ptr_q == rd_ptr_q);
        w_push_ok = bus.wr_req & ~w_full;
        w_pop_ok  = bus.rd_req & ~w_empty;
    end

    // Next-state: advance pointers on accepted ops; count tracks net change.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = w_pop_ok;
        if (w_push_ok) begin
            wr_ptr_d = wr_ptr_q + c_one;
        end
        if (w_pop_ok) begin
            rd_ptr_d = rd_ptr_q + c_one;
        end
        case ({w_push_ok, w_pop_ok})
            2'b10:   count_d = count_q + c_one;
            2'b01:   count_d = count_q - c_one;
            default: count_d = count_q;
        endcase
    end

    // State registers; async reset restores the empty FIFO and drops rd_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.wr_en        = w_push_ok;
    assign bus.wr_addr      = wr_ptr_q[ADDR_W-1:0];
    assign bus.rd_addr      = rd_ptr_q[ADDR_W-1:0];
    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.count        = count_q;
    assign bus.almost_full  = (count_q >= c_af_level);
    assign bus.almost_empty = (count_q <= c_ae_level);

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q,  overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags: set on any request that hits the wrong boundary.
    always_comb begin
        overflow_d  = overflow_q  | (bus.wr_req & w_full);
        underflow_d = underflow_q | (bus.rd_req & w_empty);
    end

    // Error flag registers, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_ctrl
// Description : Directed self-checking bench for fifo_ctrl (ADDR_W=3,
//               AF_LEVEL=6, AE_LEVEL=2) with a small register-file model
//               so data ordering through the addresses can be checked.
//               Error-flag checks are active when FIFO_ERR_FLAGS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_ctrl_if #(.ADDR_W(3)) bus ();

    fifo_ctrl #(
        .ADDR_W   (3),
        .AF_LEVEL (6),
        .AE_LEVEL (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register-file model: synchronous write, registered read.
    logic [31:0] mem [8];
    logic [31:0] wdata;
    logic [31:0] rdata;
    always @(posedge clk) begin
        if (bus.wr_en) mem[bus.wr_addr] <= wdata;
        rdata <= mem[bus.rd_addr];
    end

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q [$];
    logic [31:0] e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        bus.wr_req  = 1'b0;
        bus.rd_req  = 1'b0;
        wdata       = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1. Reset state
        chk("rst_empty",    32'(bus.empty),        1);
        chk("rst_full",     32'(bus.full),         0);
        chk("rst_count",    32'(bus.count),        0);
        chk("rst_ae",       32'(bus.almost_empty), 1);
        chk("rst_af",       32'(bus.almost_full),  0);
        chk("rst_rd_valid", 32'(bus.rd_valid),     0);
        chk("rst_wr_en",    32'(bus.wr_en),        0);

        // 2. Fill with 8 back-to-back pushes
        for (int i = 0; i < 8; i++) begin
            bus.wr_req = 1'b1;
            wdata      = 32'hA0 + 32'(i);
            #1;
            chk("fill_wr_en",   32'(bus.wr_en),   1);
            chk("fill_wr_addr", 32'(bus.wr_addr), 32'(i));
            exp_q.push_back(wdata);
            cyc();
            chk("fill_count", 32'(bus.count),       32'(i + 1));
            chk("fill_af",    32'(bus.almost_full), (i + 1 >= 6) ? 1 : 0);
            chk("fill_full",  32'(bus.full),        (i == 7) ? 1 : 0);
            chk("fill_empty", 32'(bus.empty),       0);
        end
        wdata = 32'hFF;
        #1;
        chk("ovf_wr_en", 32'(bus.wr_en), 0);
        cyc();
        chk("ovf_count", 32'(bus.count), 8);
        chk("ovf_full",  32'(bus.full),  1);
`ifdef FIFO_ERR_FLAGS_EN
        chk("ovf_flag",  32'(bus.overflow), 1);
`endif
        bus.wr_req = 1'b0;

        // 3. Drain with 8 pops
        for (int i = 0; i < 8; i++) begin
            bus.rd_req = 1'b1;
            #1;
            chk("drain_rd_addr", 32'(bus.rd_addr), 32'(i));
            cyc();
            chk("drain_rd_valid", 32'(bus.rd_valid), 1);
            e = exp_q.pop_front();
            chk("drain_rdata", rdata, e);
            chk("drain_count", 32'(bus.count), 32'(7 - i));
            chk("drain_ae",    32'(bus.almost_empty), (7 - i <= 2) ? 1 : 0);
        end
        chk("drain_empty", 32'(bus.empty), 1);
        cyc();
        chk("udf_rd_valid", 32'(bus.rd_valid), 0);
        chk("udf_count",    32'(bus.count),    0);
        chk("udf_empty",    32'(bus.empty),    1);
`ifdef FIFO_ERR_FLAGS_EN
        chk("udf_flag",     32'(bus.underflow), 1);
`endif
        bus.rd_req = 1'b0;

        // 4. Pointers now sit at the wrap-bit-set position; preload 4 then stream
        for (int i = 0; i < 4; i++) begin
            bus.wr_req = 1'b1;
            wdata      = 32'hB0 + 32'(i);
            #1;
            chk("pre_wr_addr", 32'(bus.wr_addr), 32'(i));
            exp_q.push_back(wdata);
            cyc();
        end
        chk("pre_count", 32'(bus.count), 4);
        for (int k = 0; k < 20; k++) begin
            bus.wr_req = 1'b1;
            bus.rd_req = 1'b1;
            wdata      = 32'hC0 + 32'(k);
            #1;
            chk("strm_wr_addr", 32'(bus.wr_addr), 32'((4 + k) % 8));
            chk("strm_rd_addr", 32'(bus.rd_addr), 32'(k % 8));
            exp_q.push_back(wdata);
            cyc();
            e = exp_q.pop_front();
            chk("strm_rdata",    rdata, e);
            chk("strm_rd_valid", 32'(bus.rd_valid), 1);
            chk("strm_count",    32'(bus.count),    4);
        end

        // 5a. Top up to full, then push+pop together: pop wins, push dropped
        bus.rd_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.wr_req = 1'b1;
            wdata      = 32'hD0 + 32'(i);
            #1;
            chk("top_wr_addr", 32'(bus.wr_addr), 32'(i));
            exp_q.push_back(wdata);
            cyc();
        end
        chk("top_full", 32'(bus.full), 1);
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        wdata      = 32'hEE;
        #1;
        chk("fb_wr_en", 32'(bus.wr_en), 0);
        cyc();
        chk("fb_count",    32'(bus.count),    7);
        chk("fb_rd_valid", 32'(bus.rd_valid), 1);
        e = exp_q.pop_front();
        chk("fb_rdata", rdata, e);

        // Drain the remaining 7
        bus.wr_req = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc();
            e = exp_q.pop_front();
            chk("d7_rdata", rdata, e);
        end
        chk("d7_empty", 32'(bus.empty), 1);

        // 5b. Empty + both: push accepted, pop rejected
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        wdata      = 32'h5A;
        #1;
        chk("eb_wr_en", 32'(bus.wr_en), 1);
        exp_q.push_back(wdata);
        cyc();
        chk("eb_count",    32'(bus.count),    1);
        chk("eb_rd_valid", 32'(bus.rd_valid), 0);
        chk("eb_empty",    32'(bus.empty),    0);

        // 6. Build to 5 with a pop in flight, then reset mid-cycle
        bus.rd_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wdata = 32'h60 + 32'(i);
            cyc();
        end
        chk("pre_rst_count", 32'(bus.count), 5);
        bus.rd_req = 1'b1;
        wdata      = 32'h77;
        cyc();
        chk("inflight_rd_valid", 32'(bus.rd_valid), 1);
        chk("inflight_count",    32'(bus.count),    5);
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_count",    32'(bus.count),        0);
        chk("arst_empty",    32'(bus.empty),        1);
        chk("arst_rd_valid", 32'(bus.rd_valid),     0);
        chk("arst_full",     32'(bus.full),         0);
        chk("arst_ae",       32'(bus.almost_empty), 1);
        cyc();
        rst        = 1'b0;
        bus.wr_req = 1'b1;
        wdata      = 32'h99;
        #1;
        chk("post_wr_en",   32'(bus.wr_en),   1);
        chk("post_wr_addr", 32'(bus.wr_addr), 0);
        cyc();
        chk("post_count",   32'(bus.count),   1);
`ifdef FIFO_ERR_FLAGS_EN
        chk("post_ovf", 32'(bus.overflow),  0);
        chk("post_udf", 32'(bus.underflow), 0);
`endif
        bus.wr_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
